// File: rtl/falafel_pkg.sv
// Shared widths, opcodes and message layouts for the falafel allocator blocks.
package falafel_pkg;

  localparam int DATA_W      = 32;
  localparam int MSG_ID_SIZE = 8;
  localparam int OPCODE_W    = 4;

  // Request/response opcodes carried in the header word.
  typedef enum logic [OPCODE_W-1:0] {
    REQ_NOP             = 4'd0,
    REQ_ALLOC_MEM       = 4'd1,
    REQ_FREE_MEM        = 4'd2,
    REQ_ACCESS_REGISTER = 4'd3
  } opcode_e;

  // Header word: opcode in the top bits, then the message id, rest reserved.
  typedef struct packed {
    opcode_e                                opcode;
    logic [MSG_ID_SIZE-1:0]                 id;
    logic [DATA_W-OPCODE_W-MSG_ID_SIZE-1:0] rsvd;
  } base_header_t;

  // One buffered response: message id plus its result word.
  typedef struct packed {
    logic [MSG_ID_SIZE-1:0] id;
    logic [DATA_W-1:0]      data;
  } alloc_entry_t;

endpackage

// File: rtl/falafel_fifo.sv
// Small synchronous FIFO with a combinational head output. A push and a pop
// in the same cycle both take effect; pushes are ignored while full.
module falafel_fifo #(
  parameter int DATA_W      = 32,
  parameter int NUM_ENTRIES = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int PTR_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
  localparam int CNT_W = $clog2(NUM_ENTRIES + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_ENTRIES - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_ENTRIES);

  logic [DATA_W-1:0] r_mem [NUM_ENTRIES];
  logic [PTR_W-1:0]  r_rdPtr;
  logic [PTR_W-1:0]  r_wrPtr;
  logic [CNT_W-1:0]  r_count;
  logic              w_doPush;
  logic              w_doPop;

  assign full_o   = (r_count == FULL_CNT);
  assign empty_o  = (r_count == '0);
  assign w_doPush = push_i && !full_o;
  assign w_doPop  = pop_i && !empty_o;
  assign data_o   = r_mem[r_rdPtr];

  // Storage is not reset; the occupancy count decides what is valid.
  always_ff @(posedge clk_i) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= data_i;
    end
  end

  // Pointers and occupancy, cleared by the synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= (r_wrPtr == LAST_PTR) ? '0 : r_wrPtr + 1'b1;
      end
      if (w_doPop) begin
        r_rdPtr <= (r_rdPtr == LAST_PTR) ? '0 : r_rdPtr + 1'b1;
      end
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/falafel_output_packer.sv
// Buffers alloc/free/config responses in per-channel FIFOs and serialises each
// one as a header word followed by a data word, arbitrating round-robin.
module falafel_output_packer
  import falafel_pkg::*;
#(
  parameter int NUM_FIFO_ENTRIES = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              alloc_rsp_val_i,
  output logic              alloc_rsp_rdy_o,
  input  alloc_entry_t      alloc_rsp_data_i,
  input  logic              free_rsp_val_i,
  output logic              free_rsp_rdy_o,
  input  alloc_entry_t      free_rsp_data_i,
  input  logic              config_rsp_val_i,
  output logic              config_rsp_rdy_o,
  input  alloc_entry_t      config_rsp_data_i,
  output logic              rsp_val_o,
  input  logic              rsp_rdy_i,
  output logic [DATA_W-1:0] rsp_data_o
);

  localparam int NUM_CH  = 3;
  localparam int ENTRY_W = MSG_ID_SIZE + DATA_W;

  typedef enum logic [1:0] {
    STATE_IDLE,
    STATE_SEND_HEADER,
    STATE_SEND_DATA
  } state_e;

  state_e              r_state;
  state_e              w_nextState;
  logic [1:0]          rr_q;
  logic [1:0]          grant_q;
  logic [1:0]          w_nextRr;
  logic [1:0]          w_nextGrant;
  logic [1:0]          w_pick;
  logic [NUM_CH-1:0]   w_inVal;
  logic [ENTRY_W-1:0]  w_inData [NUM_CH];
  logic [NUM_CH-1:0]   w_full;
  logic [NUM_CH-1:0]   w_empty;
  logic [NUM_CH-1:0]   w_pop;
  logic [ENTRY_W-1:0]  w_head [NUM_CH];
  alloc_entry_t        w_grantHead;
  opcode_e             w_grantOp;
  base_header_t        w_header;

  assign w_inVal     = {config_rsp_val_i, free_rsp_val_i, alloc_rsp_val_i};
  assign w_inData[0] = alloc_rsp_data_i;
  assign w_inData[1] = free_rsp_data_i;
  assign w_inData[2] = config_rsp_data_i;

  assign alloc_rsp_rdy_o  = ~w_full[0];
  assign free_rsp_rdy_o   = ~w_full[1];
  assign config_rsp_rdy_o = ~w_full[2];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_fifo
    falafel_fifo #(
      .DATA_W      (ENTRY_W),
      .NUM_ENTRIES (NUM_FIFO_ENTRIES)
    ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (w_inVal[g] && !w_full[g]),
      .data_i  (w_inData[g]),
      .pop_i   (w_pop[g]),
      .data_o  (w_head[g]),
      .full_o  (w_full[g]),
      .empty_o (w_empty[g])
    );
  end

  // Round-robin pick: first non-empty channel starting from rr_q, wrapping.
  always_comb begin
    w_pick = 2'd0;
    case (rr_q)
      2'd1: begin
        if (!w_empty[1])      w_pick = 2'd1;
        else if (!w_empty[2]) w_pick = 2'd2;
        else                  w_pick = 2'd0;
      end
      2'd2: begin
        if (!w_empty[2])      w_pick = 2'd2;
        else if (!w_empty[0]) w_pick = 2'd0;
        else                  w_pick = 2'd1;
      end
      default: begin
        if (!w_empty[0])      w_pick = 2'd0;
        else if (!w_empty[1]) w_pick = 2'd1;
        else                  w_pick = 2'd2;
      end
    endcase
  end

  // Head entry and opcode of the granted channel; stable until it is popped.
  always_comb begin
    w_grantHead = w_head[0];
    w_grantOp   = REQ_ALLOC_MEM;
    case (grant_q)
      2'd1: begin
        w_grantHead = w_head[1];
        w_grantOp   = REQ_FREE_MEM;
      end
      2'd2: begin
        w_grantHead = w_head[2];
        w_grantOp   = REQ_ACCESS_REGISTER;
      end
      default: begin
        w_grantHead = w_head[0];
        w_grantOp   = REQ_ALLOC_MEM;
      end
    endcase
    w_header        = '0;
    w_header.opcode = w_grantOp;
    w_header.id     = w_grantHead.id;
  end

  // Next-state, grant and output logic of the two-word serialiser.
  always_comb begin
    w_nextState = r_state;
    w_nextGrant = grant_q;
    w_nextRr    = rr_q;
    w_pop       = '0;
    rsp_val_o   = 1'b0;
    rsp_data_o  = '0;
    case (r_state)
      STATE_IDLE: begin
        if (|(~w_empty)) begin
          w_nextGrant = w_pick;
          w_nextState = STATE_SEND_HEADER;
        end
      end
      STATE_SEND_HEADER: begin
        rsp_val_o  = 1'b1;
        rsp_data_o = w_header;
        if (rsp_rdy_i) begin
          w_nextState = STATE_SEND_DATA;
        end
      end
      STATE_SEND_DATA: begin
        rsp_val_o  = 1'b1;
        rsp_data_o = w_grantHead.data;
        if (rsp_rdy_i) begin
          w_pop[grant_q] = 1'b1;
          w_nextRr       = (grant_q == 2'd2) ? 2'd0 : grant_q + 2'd1;
          w_nextState    = STATE_IDLE;
        end
      end
      default: begin
        w_nextState = STATE_IDLE;
      end
    endcase
  end

  // State, grant and round-robin pointer registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= STATE_IDLE;
      rr_q    <= 2'd0;
      grant_q <= 2'd0;
    end else begin
      r_state <= w_nextState;
      rr_q    <= w_nextRr;
      grant_q <= w_nextGrant;
    end
  end

endmodule

// File: tb/tb_falafel_output_packer.sv
// Directed bench for falafel_output_packer with a queue-based reference model.
module tb_falafel_output_packer;
  import falafel_pkg::*;

  localparam int DEPTH = 2;

  logic              clk;
  logic              rstN;
  logic              allocVal, freeVal, configVal;
  logic              allocRdy, freeRdy, configRdy;
  alloc_entry_t      allocData, freeData, configData;
  logic              rspVal;
  logic              rspRdy;
  logic [DATA_W-1:0] rspData;

  int compared   = 0;
  int mismatched = 0;

  falafel_output_packer #(.NUM_FIFO_ENTRIES(DEPTH)) dut (
    .clk_i             (clk),
    .rst_ni            (rstN),
    .alloc_rsp_val_i   (allocVal),
    .alloc_rsp_rdy_o   (allocRdy),
    .alloc_rsp_data_i  (allocData),
    .free_rsp_val_i    (freeVal),
    .free_rsp_rdy_o    (freeRdy),
    .free_rsp_data_i   (freeData),
    .config_rsp_val_i  (configVal),
    .config_rsp_rdy_o  (configRdy),
    .config_rsp_data_i (configData),
    .rsp_val_o         (rspVal),
    .rsp_rdy_i         (rspRdy),
    .rsp_data_o        (rspData)
  );

  // Free-running clock: rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one queue per channel holding accepted entries.
  alloc_entry_t q0[$], q1[$], q2[$];
  bit           modelArmed = 0;
  bit           mBusy = 0;
  int           mPhase = 0;
  int           mCh = 0;
  int           mRr = 0;

  function automatic int qSize(input int c);
    case (c)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic alloc_entry_t qFront(input int c);
    case (c)
      0:       return q0[0];
      1:       return q1[0];
      default: return q2[0];
    endcase
  endfunction

  task automatic qPopFront(input int c);
    case (c)
      0:       void'(q0.pop_front());
      1:       void'(q1.pop_front());
      default: void'(q2.pop_front());
    endcase
  endtask

  task automatic qPush(input int c, input alloc_entry_t e);
    case (c)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  function automatic logic [DATA_W-1:0] makeHeader(input int c, input logic [MSG_ID_SIZE-1:0] id);
    base_header_t h;
    h = '0;
    case (c)
      0:       h.opcode = REQ_ALLOC_MEM;
      1:       h.opcode = REQ_FREE_MEM;
      default: h.opcode = REQ_ACCESS_REGISTER;
    endcase
    h.id = id;
    return h;
  endfunction

  task automatic checkWord(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, then advance the model past the edge.
  always @(negedge clk) begin
    alloc_entry_t      head;
    logic [31:0]       expData;
    logic [2:0]        acc;
    if (modelArmed) begin
      expData = '0;
      if (mBusy) begin
        head    = qFront(mCh);
        expData = (mPhase == 0) ? makeHeader(mCh, head.id) : head.data;
      end
      checkWord("model_val", 32'(rspVal), 32'(mBusy));
      checkWord("model_data", rspData, expData);
      checkWord("model_alloc_rdy", 32'(allocRdy), 32'(qSize(0) < DEPTH));
      checkWord("model_free_rdy", 32'(freeRdy), 32'(qSize(1) < DEPTH));
      checkWord("model_config_rdy", 32'(configRdy), 32'(qSize(2) < DEPTH));
    end
    if (!rstN) begin
      q0.delete();
      q1.delete();
      q2.delete();
      mBusy      = 0;
      mPhase     = 0;
      mRr        = 0;
      modelArmed = 1;
    end else if (modelArmed) begin
      acc[0] = allocVal && (qSize(0) < DEPTH);
      acc[1] = freeVal && (qSize(1) < DEPTH);
      acc[2] = configVal && (qSize(2) < DEPTH);
      if (!mBusy) begin
        for (int k = 0; k < 3; k++) begin
          if (!mBusy && qSize((mRr + k) % 3) != 0) begin
            mBusy  = 1;
            mPhase = 0;
            mCh    = (mRr + k) % 3;
          end
        end
      end else if (rspRdy) begin
        if (mPhase == 0) begin
          mPhase = 1;
        end else begin
          qPopFront(mCh);
          mRr   = (mCh + 1) % 3;
          mBusy = 0;
        end
      end
      if (acc[0]) qPush(0, allocData);
      if (acc[1]) qPush(1, freeData);
      if (acc[2]) qPush(2, configData);
    end
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int ch, input logic val, input logic [7:0] id, input logic [31:0] data);
    alloc_entry_t e;
    e.id   = id;
    e.data = data;
    case (ch)
      0: begin allocVal = val;  allocData = e;  end
      1: begin freeVal = val;   freeData = e;   end
      default: begin configVal = val; configData = e; end
    endcase
  endtask

  task automatic checkOutput(input string name, input logic expVal, input logic [31:0] expData);
    @(negedge clk);
    checkWord({name, "_val"}, 32'(rspVal), 32'(expVal));
    checkWord({name, "_data"}, rspData, expData);
  endtask

  task automatic checkRdys(input string name, input logic [2:0] expRdy);
    checkWord(name, 32'({configRdy, freeRdy, allocRdy}), 32'(expRdy));
  endtask

  task automatic doReset();
    rstN = 1'b0;
    applyStimulus(0, 1'b0, 8'h0, 32'h0);
    applyStimulus(1, 1'b0, 8'h0, 32'h0);
    applyStimulus(2, 1'b0, 8'h0, 32'h0);
    nextCycle();
    rstN = 1'b1;
  endtask

  // Watchdog so the run can never hang.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rstN   = 1'b0;
    rspRdy = 1'b1;
    applyStimulus(0, 1'b0, 8'h0, 32'h0);
    applyStimulus(1, 1'b0, 8'h0, 32'h0);
    applyStimulus(2, 1'b0, 8'h0, 32'h0);
    nextCycle();

    $display("[TB] single alloc response and same-cycle push/pop");
    doReset();
    checkOutput("post_reset", 1'b0, 32'h0);
    checkRdys("post_reset_rdys", 3'b111);
    nextCycle(); applyStimulus(0, 1'b1, 8'h03, 32'h0000_1000);
    checkOutput("a_c0", 1'b0, 32'h0);
    nextCycle(); applyStimulus(0, 1'b0, 8'h00, 32'hDEAD_BEEF);
    checkOutput("a_c1", 1'b0, 32'h0);
    nextCycle(); checkOutput("a_hdr", 1'b1, 32'h1030_0000);
    nextCycle(); applyStimulus(0, 1'b1, 8'h0B, 32'h0000_2000);
    checkOutput("a_data", 1'b1, 32'h0000_1000);
    nextCycle(); applyStimulus(0, 1'b0, 8'h00, 32'h0);
    checkOutput("a_idle", 1'b0, 32'h0);
    nextCycle(); checkOutput("b_hdr", 1'b1, 32'h10B0_0000);
    nextCycle(); checkOutput("b_data", 1'b1, 32'h0000_2000);
    nextCycle(); checkOutput("b_idle", 1'b0, 32'h0);

    $display("[TB] backpressure on header");
    doReset();
    rspRdy = 1'b0;
    nextCycle(); applyStimulus(0, 1'b1, 8'h05, 32'h0000_ABCD);
    nextCycle(); applyStimulus(0, 1'b0, 8'h00, 32'h0);
    for (int i = 0; i < 5; i++) begin
      nextCycle(); checkOutput("bp_hold", 1'b1, 32'h1050_0000);
    end
    nextCycle(); rspRdy = 1'b1;
    checkOutput("bp_release", 1'b1, 32'h1050_0000);
    nextCycle(); checkOutput("bp_data", 1'b1, 32'h0000_ABCD);
    nextCycle(); checkOutput("bp_idle", 1'b0, 32'h0);

    $display("[TB] round-robin across three channels");
    doReset();
    rspRdy = 1'b1;
    nextCycle();
    applyStimulus(0, 1'b1, 8'h01, 32'h0000_00A1);
    applyStimulus(1, 1'b1, 8'h02, 32'h0000_00B2);
    applyStimulus(2, 1'b1, 8'h03, 32'h0000_00C3);
    nextCycle();
    applyStimulus(0, 1'b0, 8'h00, 32'h0);
    applyStimulus(1, 1'b0, 8'h00, 32'h0);
    applyStimulus(2, 1'b0, 8'h00, 32'h0);
    nextCycle(); checkOutput("rr_alloc_hdr", 1'b1, 32'h1010_0000);
    nextCycle(); checkOutput("rr_alloc_data", 1'b1, 32'h0000_00A1);
    nextCycle(); checkOutput("rr_idle0", 1'b0, 32'h0);
    nextCycle(); checkOutput("rr_free_hdr", 1'b1, 32'h2020_0000);
    nextCycle(); checkOutput("rr_free_data", 1'b1, 32'h0000_00B2);
    nextCycle(); checkOutput("rr_idle1", 1'b0, 32'h0);
    nextCycle(); checkOutput("rr_cfg_hdr", 1'b1, 32'h3030_0000);
    nextCycle(); checkOutput("rr_cfg_data", 1'b1, 32'h0000_00C3);
    nextCycle(); applyStimulus(1, 1'b1, 8'h04, 32'h0000_00B4);
    applyStimulus(2, 1'b1, 8'h05, 32'h0000_00C5);
    checkOutput("rr_idle2", 1'b0, 32'h0);
    nextCycle();
    applyStimulus(1, 1'b0, 8'h00, 32'h0);
    applyStimulus(2, 1'b0, 8'h00, 32'h0);
    checkOutput("rr_idle3", 1'b0, 32'h0);
    nextCycle(); checkOutput("rr2_free_hdr", 1'b1, 32'h2040_0000);
    nextCycle(); checkOutput("rr2_free_data", 1'b1, 32'h0000_00B4);
    nextCycle(); checkOutput("rr2_idle", 1'b0, 32'h0);
    nextCycle(); checkOutput("rr2_cfg_hdr", 1'b1, 32'h3050_0000);
    nextCycle(); checkOutput("rr2_cfg_data", 1'b1, 32'h0000_00C5);

    $display("[TB] free FIFO full");
    doReset();
    rspRdy = 1'b0;
    nextCycle(); applyStimulus(1, 1'b1, 8'h06, 32'h0000_0600);
    nextCycle(); applyStimulus(1, 1'b1, 8'h07, 32'h0000_0700);
    checkOutput("full_c1", 1'b0, 32'h0);
    checkRdys("full_c1_rdys", 3'b111);
    nextCycle(); applyStimulus(1, 1'b1, 8'h08, 32'h0000_0800);
    checkOutput("full_c2", 1'b1, 32'h2060_0000);
    checkRdys("full_c2_rdys", 3'b101);
    nextCycle(); checkOutput("full_c3", 1'b1, 32'h2060_0000);
    checkRdys("full_c3_rdys", 3'b101);
    nextCycle(); checkOutput("full_c4", 1'b1, 32'h2060_0000);
    nextCycle(); rspRdy = 1'b1;
    checkOutput("full_c5", 1'b1, 32'h2060_0000);
    checkRdys("full_c5_rdys", 3'b101);
    nextCycle(); checkOutput("full_c6_data", 1'b1, 32'h0000_0600);
    checkRdys("full_c6_rdys", 3'b101);
    nextCycle(); checkOutput("full_c7_idle", 1'b0, 32'h0);
    checkRdys("full_c7_rdys", 3'b111);
    nextCycle(); applyStimulus(1, 1'b0, 8'h00, 32'h0);
    checkOutput("full_id7_hdr", 1'b1, 32'h2070_0000);
    checkRdys("full_c8_rdys", 3'b101);
    nextCycle(); checkOutput("full_id7_data", 1'b1, 32'h0000_0700);
    nextCycle(); checkOutput("full_c10_idle", 1'b0, 32'h0);
    nextCycle(); checkOutput("full_id8_hdr", 1'b1, 32'h2080_0000);
    nextCycle(); checkOutput("full_id8_data", 1'b1, 32'h0000_0800);
    nextCycle(); checkOutput("full_c13_idle", 1'b0, 32'h0);
    checkRdys("full_c13_rdys", 3'b111);

    $display("[TB] reset during data word");
    doReset();
    rspRdy = 1'b1;
    nextCycle(); applyStimulus(0, 1'b1, 8'h09, 32'h0000_0900);
    nextCycle(); applyStimulus(0, 1'b0, 8'h00, 32'h0);
    applyStimulus(1, 1'b1, 8'h0A, 32'h0000_0A00);
    nextCycle(); applyStimulus(1, 1'b0, 8'h00, 32'h0);
    checkOutput("rst_hdr", 1'b1, 32'h1090_0000);
    nextCycle(); rspRdy = 1'b0;
    checkOutput("rst_data_stall", 1'b1, 32'h0000_0900);
    nextCycle(); rstN = 1'b0;
    checkOutput("rst_data_inreset", 1'b1, 32'h0000_0900);
    nextCycle(); rstN = 1'b1; rspRdy = 1'b1;
    checkOutput("rst_after", 1'b0, 32'h0);
    checkRdys("rst_after_rdys", 3'b111);
    for (int i = 0; i < 8; i++) begin
      nextCycle(); checkOutput("rst_quiet", 1'b0, 32'h0);
    end

    nextCycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
